// File: rtl/branch_pkg.sv
// ----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch resolution logic: branch op-code
// constants, the resolver FSM state type and the flag-condition evaluator.
// cond_taken is kept here so a future predictor can reuse the same rules.
// ----------------------------------------------------------------------------
package branch_pkg;

    localparam logic [3:0] OpZero       = 4'd0;
    localparam logic [3:0] OpNotZero    = 4'd1;
    localparam logic [3:0] OpEqual      = 4'd2;
    localparam logic [3:0] OpNotEqual   = 4'd3;
    localparam logic [3:0] OpGreater    = 4'd4;
    localparam logic [3:0] OpLess       = 4'd5;
    localparam logic [3:0] OpGreatEqual = 4'd6;
    localparam logic [3:0] OpLessEqual  = 4'd7;
    localparam logic [3:0] OpCarry      = 4'd8;
    localparam logic [3:0] OpNotCarry   = 4'd9;
    localparam logic [3:0] OpUncond     = 4'd10;
    localparam logic [3:0] OpCall       = 4'd11;
    localparam logic [3:0] OpRet        = 4'd12;
    localparam logic [3:0] OpRsvd13     = 4'd13;
    localparam logic [3:0] OpRsvd14     = 4'd14;
    localparam logic [3:0] OpRsvd15     = 4'd15;

    typedef enum logic [0:0] {
        StIdle,
        StFlush
    } brs_state_e;

    // Flag-only decision. CALL/RET and reserved codes return 0 here; the
    // caller handles CALL/RET since they depend on stack state, not flags.
    function automatic logic cond_taken(input logic [3:0] op, input logic c,
                                        input logic s, input logic z);
        logic taken;
        taken = 1'b0;
        case (op)
            OpZero, OpEqual:       taken = z;
            OpNotZero, OpNotEqual: taken = ~z;
            OpGreater:             taken = ~s & ~z;
            OpLess:                taken = s & ~z;
            OpGreatEqual:          taken = ~s | z;
            OpLessEqual:           taken = s | z;
            OpCarry:               taken = c;
            OpNotCarry:            taken = ~c;
            OpUncond:              taken = 1'b1;
            default:               taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/return_addr_stack.sv
// ----------------------------------------------------------------------------
// return_addr_stack
// Circular return-address stack with a saturating occupancy count. A push
// when full overwrites the oldest entry (the write pointer simply wraps onto
// it) and the count stays at RAS_DEPTH. A pop when empty is ignored.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   push       write push_addr at the top
//   pop        discard the top entry
//   push_addr  address to push
//   top_addr   current top entry (meaningful when !empty)
//   empty      no entries
//   full       RAS_DEPTH entries
// ----------------------------------------------------------------------------
module return_addr_stack
    import branch_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] top_addr,
    output logic              empty,
    output logic              full
);

    localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PtrW-1:0]   r_ptr;     // next slot to write
    logic [CntW-1:0]   r_cnt;
    logic [PtrW-1:0]   w_top_idx;

    assign w_top_idx = r_ptr - 1'b1;
    assign top_addr  = r_mem[w_top_idx];
    assign empty     = (r_cnt == '0);
    assign full      = (r_cnt == CntW'(RAS_DEPTH));

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_ptr] <= push_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (push) begin
            r_ptr <= r_ptr + 1'b1;
            if (!full) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (pop && !empty) begin
            r_ptr <= r_ptr - 1'b1;
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
// Latches ALU flags and resolves conditional, unconditional, CALL and RET
// branches. A taken branch produces a one-cycle registered redirect with its
// target, then flush is held for FLUSH_CYCLES unstalled cycles.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   flags_we, carry/sign/zero  flag register load (bypassed to the decision)
//   br_valid, br_op            branch present and its op code
//   br_target                  taken target for jumps and CALL
//   pc_next                    return address pushed by CALL
//   stall                      freezes acceptance and the flush counter
//   redirect, redirect_pc      one-cycle redirect pulse and target
//   flush                      squash younger instructions
//   ras_overflow/underflow     one-cycle stack error pulses
// ----------------------------------------------------------------------------
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned RAS_DEPTH    = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flags_we,
    input  logic              carry,
    input  logic              sign,
    input  logic              zero,
    input  logic              br_valid,
    input  logic [3:0]        br_op,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] pc_next,
    input  logic              stall,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    localparam int unsigned CntW = $clog2(FLUSH_CYCLES + 1);

    logic              r_c, r_s, r_z;
    logic              w_c, w_s, w_z;
    brs_state_e        r_state, w_state_nxt;
    logic [CntW-1:0]   r_cnt, w_cnt_nxt;
    logic              r_redirect;
    logic [ADDR_W-1:0] r_redirect_pc;
    logic              r_ovf, r_unf;

    logic              w_accept, w_is_call, w_is_ret, w_taken, w_fire;
    logic [ADDR_W-1:0] w_target;
    logic              w_push, w_pop;
    logic [ADDR_W-1:0] w_ras_top;
    logic              w_ras_empty, w_ras_full;

    // Same-cycle flag write is bypassed so a compare+branch pair resolves
    // without a bubble.
    assign w_c = flags_we ? carry : r_c;
    assign w_s = flags_we ? sign  : r_s;
    assign w_z = flags_we ? zero  : r_z;

    // Anything arriving during FLUSH is being squashed, so it is ignored.
    assign w_accept  = br_valid && !stall && (r_state == StIdle);
    assign w_is_call = (br_op == OpCall);
    assign w_is_ret  = (br_op == OpRet);

    always_comb begin
        w_taken  = 1'b0;
        w_target = br_target;
        if (w_is_call) begin
            w_taken = 1'b1;
        end else if (w_is_ret) begin
            // RET on an empty stack has nowhere to go: not taken.
            w_taken  = !w_ras_empty;
            w_target = w_ras_top;
        end else begin
            w_taken = cond_taken(br_op, w_c, w_s, w_z);
        end
    end

    assign w_fire = w_accept && w_taken;
    assign w_push = w_accept && w_is_call;
    assign w_pop  = w_accept && w_is_ret && !w_ras_empty;

    return_addr_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_addr (pc_next),
        .top_addr  (w_ras_top),
        .empty     (w_ras_empty),
        .full      (w_ras_full)
    );

    // Flag register: honoured regardless of stall or FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c <= 1'b0;
            r_s <= 1'b0;
            r_z <= 1'b0;
        end else if (flags_we) begin
            r_c <= carry;
            r_s <= sign;
            r_z <= zero;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FSM next state: the counter holds the remaining flush cycles, counting
    // the current one, and freezes while stalled.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_fire) begin
                    w_state_nxt = StFlush;
                    w_cnt_nxt   = CntW'(FLUSH_CYCLES);
                end
            end
            StFlush: begin
                if (!stall) begin
                    if (r_cnt == CntW'(1)) begin
                        w_state_nxt = StIdle;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_ovf         <= 1'b0;
            r_unf         <= 1'b0;
        end else begin
            r_redirect <= w_fire;
            if (w_fire) begin
                r_redirect_pc <= w_target;
            end
            r_ovf <= w_accept && w_is_call && w_ras_full;
            r_unf <= w_accept && w_is_ret && w_ras_empty;
        end
    end

    assign redirect      = r_redirect;
    assign redirect_pc   = r_redirect_pc;
    assign flush         = (r_state == StFlush);
    assign ras_overflow  = r_ovf;
    assign ras_underflow = r_unf;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed scenarios with literal expectations, a flag/op sweep and a
// randomized phase, all compared every cycle against a queue-based model.
// ----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned FLUSH  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flags_we = 1'b0, carry = 1'b0, sign = 1'b0, zero = 1'b0;
    logic              br_valid = 1'b0;
    logic [3:0]        br_op = 4'd0;
    logic [ADDR_W-1:0] br_target = '0, pc_next = '0;
    logic              stall = 1'b0;
    logic              redirect, flush, ras_overflow, ras_underflow;
    logic [ADDR_W-1:0] redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;

    branch_resolve_unit #(
        .ADDR_W       (ADDR_W),
        .RAS_DEPTH    (DEPTH),
        .FLUSH_CYCLES (FLUSH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flags_we      (flags_we),
        .carry         (carry),
        .sign          (sign),
        .zero          (zero),
        .br_valid      (br_valid),
        .br_op         (br_op),
        .br_target     (br_target),
        .pc_next       (pc_next),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .flush         (flush),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic              m_valid = 1'b0;
    logic              m_c = 1'b0, m_s = 1'b0, m_z = 1'b0;
    logic [ADDR_W-1:0] ras_q[$];
    int                flush_left = 0;
    logic              e_red = 1'b0, e_flush = 1'b0, e_ovf = 1'b0, e_unf = 1'b0;
    logic [ADDR_W-1:0] e_pc = '0;

    function automatic logic spec_taken(input logic [3:0] op, input logic c,
                                        input logic s, input logic z);
        case (op)
            4'd0, 4'd2: return z;
            4'd1, 4'd3: return !z;
            4'd4:       return !s && !z;
            4'd5:       return s && !z;
            4'd6:       return !s || z;
            4'd7:       return s || z;
            4'd8:       return c;
            4'd9:       return !c;
            4'd10:      return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        logic              ec, es, ez, in_fl, acc, tk;
        logic [ADDR_W-1:0] tgt;
        if (rst) begin
            m_c = 1'b0; m_s = 1'b0; m_z = 1'b0;
            ras_q.delete();
            flush_left = 0;
            e_red = 1'b0; e_flush = 1'b0; e_ovf = 1'b0; e_unf = 1'b0; e_pc = '0;
            m_valid = 1'b1;
            return;
        end
        ec = flags_we ? carry : m_c;
        es = flags_we ? sign  : m_s;
        ez = flags_we ? zero  : m_z;
        in_fl = (flush_left > 0);
        acc = br_valid && !stall && !in_fl;
        tk = 1'b0;
        tgt = br_target;
        e_red = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
        if (acc) begin
            if (br_op == 4'd11) begin
                if (ras_q.size() == DEPTH) begin
                    ras_q.delete(0);
                    e_ovf = 1'b1;
                end
                ras_q.push_back(pc_next);
                tk = 1'b1;
            end else if (br_op == 4'd12) begin
                if (ras_q.size() == 0) e_unf = 1'b1;
                else begin
                    tgt = ras_q.pop_back();
                    tk = 1'b1;
                end
            end else begin
                tk = spec_taken(br_op, ec, es, ez);
            end
        end
        if (in_fl && !stall) flush_left = flush_left - 1;
        if (tk) begin
            flush_left = FLUSH;
            e_red = 1'b1;
            e_pc = tgt;
        end
        e_flush = (flush_left > 0);
        if (flags_we) begin
            m_c = carry; m_s = sign; m_z = zero;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle comparison ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("cmp_redirect", 64'(redirect), 64'(e_red));
            chk("cmp_flush", 64'(flush), 64'(e_flush));
            chk("cmp_ovf", 64'(ras_overflow), 64'(e_ovf));
            chk("cmp_unf", 64'(ras_underflow), 64'(e_unf));
            if (e_red) chk("cmp_redirect_pc", 64'(redirect_pc), 64'(e_pc));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present a branch for one cycle; returns at the negedge where its
    // registered result is visible.
    task automatic br(input logic [3:0] op, input logic [ADDR_W-1:0] tgt,
                      input logic [ADDR_W-1:0] pcn);
        br_valid = 1'b1; br_op = op; br_target = tgt; pc_next = pcn;
        @(negedge clk);
        br_valid = 1'b0; flags_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle(2);
        chk("reset_redirect", 64'(redirect), 64'd0);
        chk("reset_redirect_pc", 64'(redirect_pc), 64'd0);
        chk("reset_flush", 64'(flush), 64'd0);
        chk("reset_ovf_unf", 64'({ras_overflow, ras_underflow}), 64'd0);
        rst = 1'b0;
        idle(1);

        // Flag bypass: LESS taken, GREATER not, with s=1 z=0 written same cycle.
        flags_we = 1'b1; carry = 1'b0; sign = 1'b1; zero = 1'b0;
        br(4'd5, 32'h100, '0);
        chk("bypass_less_redirect", 64'(redirect), 64'd1);
        chk("bypass_less_pc", 64'(redirect_pc), 64'h100);
        chk("bypass_less_flush", 64'(flush), 64'd1);
        idle(4);
        flags_we = 1'b1; sign = 1'b1; zero = 1'b0;
        br(4'd4, 32'h200, '0);
        chk("bypass_greater_redirect", 64'(redirect), 64'd0);
        chk("bypass_greater_flush", 64'(flush), 64'd0);
        idle(1);

        // CALL/RET pairing, then RET on the now-empty stack.
        br(4'd11, 32'h80, 32'h10);
        chk("call_pc", 64'(redirect_pc), 64'h80);
        idle(4);
        br(4'd12, '0, '0);
        chk("ret_redirect", 64'(redirect), 64'd1);
        chk("ret_pc", 64'(redirect_pc), 64'h10);
        idle(4);
        br(4'd12, '0, '0);
        chk("ret_empty_unf", 64'(ras_underflow), 64'd1);
        chk("ret_empty_redirect", 64'(redirect), 64'd0);
        idle(2);

        // Overflow: five CALLs into a 4-deep stack, then five RETs.
        for (int i = 1; i <= 5; i++) begin
            br(4'd11, 32'h1000 + i, 32'(i));
            chk("call_ovf", 64'(ras_overflow), (i == 5) ? 64'd1 : 64'd0);
            idle(4);
        end
        for (int i = 0; i < 5; i++) begin
            br(4'd12, '0, '0);
            if (i < 4) begin
                chk("ovf_ret_pc", 64'(redirect_pc), 64'(5 - i));
            end else begin
                chk("ovf_ret5_unf", 64'(ras_underflow), 64'd1);
                chk("ovf_ret5_redirect", 64'(redirect), 64'd0);
            end
            idle(4);
        end

        // Flush extended by a stall; UNCOND during flush is squashed.
        br(4'd10, 32'h300, '0);
        stall = 1'b1;
        chk("stall_flush_n1", 64'(flush), 64'd1);
        @(negedge clk);
        stall = 1'b0;
        chk("stall_flush_n2", 64'(flush), 64'd1);
        br_valid = 1'b1; br_op = 4'd10; br_target = 32'h999;
        @(negedge clk);
        br_valid = 1'b0;
        chk("stall_flush_n3", 64'(flush), 64'd1);
        chk("squashed_no_redirect", 64'(redirect), 64'd0);
        @(negedge clk);
        chk("stall_flush_n4", 64'(flush), 64'd0);
        chk("squashed_no_redirect2", 64'(redirect), 64'd0);
        idle(2);

        // Reserved ops leave the stack untouched.
        br(4'd11, 32'h500, 32'h77);
        idle(4);
        for (int op = 13; op <= 15; op++) begin
            br(4'(op), 32'h600, 32'h88);
            chk("rsvd_redirect", 64'(redirect), 64'd0);
            chk("rsvd_flush", 64'(flush), 64'd0);
        end
        br(4'd12, '0, '0);
        chk("rsvd_ras_kept", 64'(redirect_pc), 64'h77);
        idle(4);

        // Reset asserted in the first flush cycle.
        br(4'd10, 32'h40, '0);
        chk("midrst_redirect", 64'(redirect), 64'd1);
        chk("midrst_pc", 64'(redirect_pc), 64'h40);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_cleared_redirect", 64'(redirect), 64'd0);
        chk("midrst_cleared_flush", 64'(flush), 64'd0);
        chk("midrst_cleared_pc", 64'(redirect_pc), 64'd0);
        idle(1);
        br(4'd10, 32'h50, '0);
        chk("after_rst_redirect", 64'(redirect), 64'd1);
        chk("after_rst_pc", 64'(redirect_pc), 64'h50);
        idle(4);

        // Sweep ops 0..10 over all flag combinations (model compares).
        for (int op = 0; op <= 10; op++) begin
            for (int f = 0; f < 8; f++) begin
                flags_we = 1'b1;
                {carry, sign, zero} = 3'(f);
                br(4'(op), 32'h2000 + 32'(op * 8 + f), '0);
                idle(3);
            end
        end

        // Randomized phase.
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flags_we  = ($urandom_range(0, 2) == 0);
            carry     = 1'($urandom);
            sign      = 1'($urandom);
            zero      = 1'($urandom);
            br_valid  = 1'($urandom);
            br_op     = ($urandom_range(0, 2) == 0) ? 4'(11 + $urandom_range(0, 1))
                                                    : 4'($urandom_range(0, 15));
            br_target = $urandom;
            pc_next   = $urandom;
            stall     = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        rst = 1'b0; br_valid = 1'b0; flags_we = 1'b0; stall = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
